// File: rtl/psram_access_arbiter_pkg.sv
// rtl/psram_access_arbiter_pkg.sv - shared state encoding and command constants
package psram_access_arbiter_types;

  typedef enum logic [7:0] {
    IDLE     = 8'd0,
    GRANT_WR = 8'd1,
    GRANT_RD = 8'd2,
    HOLD     = 8'd3,
    RELEASE  = 8'd4
  } t_state;

  localparam logic MEM_CMD_WRITE = 1'b1;
  localparam logic MEM_CMD_READ  = 1'b0;

endpackage

// File: rtl/psram_access_arbiter.sv
// rtl/psram_access_arbiter.sv - round-robin write/read arbiter for the PSRAM command port
// Grants one burst at a time, then holds data-path ownership for TCMD cycles.
module psram_access_arbiter
  import psram_access_arbiter_types::*;
#(
  parameter int TCMD       = 19,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_init_done,
  input  logic                  wr_rq,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_ack,
  input  logic                  rd_rq,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic                  mem_cmd,
  output logic                  mem_cmd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  wr_owner,
  output logic                  rd_owner
);

  // GRANT covers the first owner cycle, so HOLD spans the remaining TCMD-1.
  localparam logic [5:0] HOLD_LAST = 6'(TCMD - 2);

  t_state                r_state;
  logic [5:0]            r_hold_cnt;
  logic                  r_last_wr;
  logic                  r_wr_ack;
  logic                  r_rd_ack;
  logic                  r_mem_cmd;
  logic                  r_mem_cmd_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_wr_owner;
  logic                  r_rd_owner;

  logic                  w_req_any;
  logic                  w_pick_wr;

  function automatic logic pick_wr(input logic wr, input logic rd, input logic last_wr);
    return wr & (~rd | ~last_wr);
  endfunction

  assign w_req_any = mem_init_done & (wr_rq | rd_rq);
  assign w_pick_wr = pick_wr(wr_rq, rd_rq, r_last_wr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_hold_cnt   <= 6'd0;
      r_last_wr    <= 1'b1;
      r_wr_ack     <= 1'b0;
      r_rd_ack     <= 1'b0;
      r_mem_cmd    <= 1'b0;
      r_mem_cmd_en <= 1'b0;
      r_mem_addr   <= '0;
      r_wr_owner   <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_mem_cmd_en <= 1'b1;
            r_last_wr    <= w_pick_wr;
            if (w_pick_wr) begin
              r_state    <= GRANT_WR;
              r_wr_ack   <= 1'b1;
              r_wr_owner <= 1'b1;
              r_mem_cmd  <= MEM_CMD_WRITE;
              r_mem_addr <= wr_addr;
            end else begin
              r_state    <= GRANT_RD;
              r_rd_ack   <= 1'b1;
              r_rd_owner <= 1'b1;
              r_mem_cmd  <= MEM_CMD_READ;
              r_mem_addr <= rd_addr;
            end
          end
        end
        GRANT_WR, GRANT_RD: begin
          r_wr_ack     <= 1'b0;
          r_rd_ack     <= 1'b0;
          r_mem_cmd_en <= 1'b0;
          r_hold_cnt   <= 6'd0;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_wr_owner <= 1'b0;
            r_rd_owner <= 1'b0;
            r_state    <= RELEASE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 6'd1;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
        end
        default: begin
          r_wr_ack     <= 1'b0;
          r_rd_ack     <= 1'b0;
          r_mem_cmd_en <= 1'b0;
          r_wr_owner   <= 1'b0;
          r_rd_owner   <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign wr_ack     = r_wr_ack;
  assign rd_ack     = r_rd_ack;
  assign mem_cmd    = r_mem_cmd;
  assign mem_cmd_en = r_mem_cmd_en;
  assign mem_addr   = r_mem_addr;
  assign wr_owner   = r_wr_owner;
  assign rd_owner   = r_rd_owner;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// tb/tb_psram_access_arbiter.sv - scoreboard bench for psram_access_arbiter
module tb_psram_access_arbiter;

  localparam int TCMD = 19;
  localparam int AW   = 21;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_init_done;
  logic          wr_rq;
  logic [AW-1:0] wr_addr;
  logic          wr_ack;
  logic          rd_rq;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          mem_cmd;
  logic          mem_cmd_en;
  logic [AW-1:0] mem_addr;
  logic          wr_owner;
  logic          rd_owner;

  psram_access_arbiter #(.TCMD(TCMD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .mem_init_done(mem_init_done),
    .wr_rq(wr_rq), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .rd_rq(rd_rq), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
    .wr_owner(wr_owner), .rd_owner(rd_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cmd;
    logic [AW-1:0] addr;
    logic          is_wr;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_grants = 0;
  int   wcnt     = 0;
  int   rcnt     = 0;
  logic prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic cmd, input logic [AW-1:0] addr, input logic is_wr, input int c);
    exp_t e;
    e.cmd = cmd; e.addr = addr; e.is_wr = is_wr; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(wr_ack == 1'b0,     {tag, "_wr_ack"},     wr_ack, 0);
    chk(rd_ack == 1'b0,     {tag, "_rd_ack"},     rd_ack, 0);
    chk(mem_cmd_en == 1'b0, {tag, "_mem_cmd_en"}, mem_cmd_en, 0);
    chk(mem_cmd == 1'b0,    {tag, "_mem_cmd"},    mem_cmd, 0);
    chk(mem_addr == '0,     {tag, "_mem_addr"},   mem_addr, 0);
    chk(wr_owner == 1'b0,   {tag, "_wr_owner"},   wr_owner, 0);
    chk(rd_owner == 1'b0,   {tag, "_rd_owner"},   rd_owner, 0);
  endtask

  // Monitor: pops the scoreboard on every command strobe and checks invariants.
  always @(negedge clk) begin
    exp_t ex;
    if (!reset_n) begin
      wcnt     = 0;
      rcnt     = 0;
      prev_ack = 1'b0;
    end else begin
      if (mem_cmd_en) begin
        n_grants++;
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_cmd", mem_addr, 0);
        end else begin
          ex = sb.pop_front();
          chk(mem_cmd == ex.cmd, "cmd_dir", mem_cmd, ex.cmd);
          chk(mem_addr == ex.addr, "cmd_addr", mem_addr, ex.addr);
          chk(wr_ack == ex.is_wr && rd_ack == !ex.is_wr, "ack_port", {wr_ack, rd_ack}, {ex.is_wr, !ex.is_wr});
          chk(cyc == ex.cyc, "grant_cycle", cyc, ex.cyc);
        end
      end
      chk(!(wr_owner && rd_owner), "owner_overlap", {wr_owner, rd_owner}, 0);
      chk(mem_cmd_en == (wr_ack | rd_ack) && !(wr_ack && rd_ack), "ack_vs_cmd_en",
          {wr_ack, rd_ack, mem_cmd_en}, mem_cmd_en);
      if (prev_ack) chk(!(wr_ack | rd_ack), "ack_width", 2, 1);
      prev_ack = wr_ack | rd_ack;
      if (wr_owner) wcnt++;
      else if (wcnt != 0) begin
        chk(wcnt == TCMD, "wr_owner_len", wcnt, TCMD);
        wcnt = 0;
      end
      if (rd_owner) rcnt++;
      else if (rcnt != 0) begin
        chk(rcnt == TCMD, "rd_owner_len", rcnt, TCMD);
        rcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int g0;
    reset_n = 1'b0; mem_init_done = 1'b0;
    wr_rq = 1'b0; rd_rq = 1'b0; wr_addr = '0; rd_addr = '0;
    tick(); tick(); tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // No grant while calibration is incomplete.
    wr_addr = 21'h00ABC; wr_rq = 1'b1;
    repeat (50) tick();
    chk(n_grants == 0, "init_gate", n_grants, 0);
    e = cyc; mem_init_done = 1'b1;
    push(1'b1, 21'h00ABC, 1'b1, e + 1);
    wait_until(e + 3); wr_rq = 1'b0;
    wait_until(e + 30);

    // Single write held high: second grant shows the TCMD+2 period.
    e = cyc; wr_addr = 21'h1F000; wr_rq = 1'b1;
    push(1'b1, 21'h1F000, 1'b1, e + 1);
    push(1'b1, 21'h1F000, 1'b1, e + 1 + TCMD + 2);
    wait_until(e + 23); wr_rq = 1'b0;
    wait_until(e + 45);

    // Read request arriving during a write HOLD.
    e = cyc; wr_addr = 21'h00777; wr_rq = 1'b1;
    push(1'b1, 21'h00777, 1'b1, e + 1);
    wait_until(e + 5); wr_rq = 1'b0; rd_addr = 21'h054321; rd_rq = 1'b1;
    push(1'b0, 21'h054321, 1'b0, e + 22);
    wait_until(e + 23); rd_rq = 1'b0;
    wait_until(e + 45);

    // Both requests high out of reset: rd, wr, rd, wr.
    reset_n = 1'b0; #1;
    check_reset_outputs("rst_idle");
    wr_addr = 21'h12345; rd_addr = 21'h0ABCD; wr_rq = 1'b1; rd_rq = 1'b1;
    tick(); tick();
    e = cyc; reset_n = 1'b1;
    push(1'b0, 21'h0ABCD, 1'b0, e + 1);
    push(1'b1, 21'h12345, 1'b1, e + 22);
    push(1'b0, 21'h0ABCD, 1'b0, e + 43);
    push(1'b1, 21'h12345, 1'b1, e + 64);
    wait_until(e + 65); wr_rq = 1'b0; rd_rq = 1'b0;
    wait_until(e + 90);

    // Reset in the middle of a read HOLD; first tie afterwards goes to the reader.
    e = cyc; rd_addr = 21'h1ABCD; rd_rq = 1'b1;
    push(1'b0, 21'h1ABCD, 1'b0, e + 1);
    wait_until(e + 12); rd_rq = 1'b0; reset_n = 1'b0; #1;
    check_reset_outputs("rst_mid");
    wr_addr = 21'h00F0F; wr_rq = 1'b1; rd_rq = 1'b1;
    wait_until(e + 14); reset_n = 1'b1;
    push(1'b0, 21'h1ABCD, 1'b0, e + 15);
    wait_until(e + 16); wr_rq = 1'b0; rd_rq = 1'b0;
    wait_until(e + 40);

    // Calibration lost during HOLD: burst completes, no further grant.
    g0 = n_grants;
    e = cyc; wr_addr = 21'h0C0DE; wr_rq = 1'b1;
    push(1'b1, 21'h0C0DE, 1'b1, e + 1);
    wait_until(e + 6); mem_init_done = 1'b0;
    wait_until(e + 70);
    chk(n_grants == g0 + 1, "init_drop_grants", n_grants - g0, 1);
    wr_rq = 1'b0;
    tick(); tick();

    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
